// File: rtl/onchip_block_fetcher_if.sv
// Bus bundle for onchip_block_fetcher: the Avalon-MM read port toward the on-chip
// message RAM plus the valid/ready word stream toward the hash cores.
// master = fetcher side, slave = RAM/consumer side.

interface onchip_block_fetcher_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);

  // Avalon-MM read master toward the RAM
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  // Word stream toward the hash cores
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output mem_address,
    output mem_byteenable,
    output mem_chipselect,
    output mem_write,
    output mem_writedata,
    output mem_clken,
    input  mem_readdata,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  mem_address,
    input  mem_byteenable,
    input  mem_chipselect,
    input  mem_write,
    input  mem_writedata,
    input  mem_clken,
    output mem_readdata,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/onchip_block_fetcher.sv
// onchip_block_fetcher: reads num_blocks consecutive 16-word SHA-2 blocks from a
// 1-cycle-latency single-port RAM and streams them out through a small FIFO,
// flagging the last word of every block. Reads are credit-limited so the FIFO can
// never overflow. Never writes the RAM.
// Optional build macro FETCH_BYTESWAP_EN: byte-reverse every word before the FIFO.

module onchip_block_fetcher #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_WORDS   = 64000,
  parameter int unsigned BLOCK_WORDS = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [15:0]               num_blocks,
  output logic                      busy,
  output logic                      done,
  onchip_block_fetcher_if.master    bus
);

  localparam int unsigned CntW  = ADDR_W + 4;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned BeatW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CntW-1:0]       remain_q;
  logic [BeatW-1:0]      beat_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PtrW-1:0]       wptr_q;
  logic [PtrW-1:0]       rptr_q;
  logic [PtrW:0]         count_q;

  logic [PtrW+1:0]       credits_used;
  logic                  issue;
  logic                  last_beat;
  logic                  push;
  logic                  pop;
  logic                  out_valid;
  logic [ADDR_W-1:0]     base_wrapped;
  logic [ADDR_W-1:0]     addr_next;
  logic [CntW-1:0]       total_words;
  logic [DATA_W-1:0]     wdata;

  // Credit check uses only registered counts; a pop this cycle frees its slot next cycle.
  always_comb begin
    credits_used = {1'b0, count_q} + {{(PtrW + 1){1'b0}}, inflight_q};
    issue        = (state_q == StFetch) && (credits_used < (PtrW + 2)'(FIFO_DEPTH));
    last_beat    = (beat_q == BeatW'(BLOCK_WORDS - 1));
    out_valid    = (count_q != '0);
    push         = inflight_q;
    pop          = out_valid && bus.out_ready;
    total_words  = CntW'(num_blocks) * CntW'(BLOCK_WORDS);
  end

  // Address arithmetic: one subtraction suffices since MEM_WORDS > 2^(ADDR_W-1).
  always_comb begin
    base_wrapped = base_addr;
    if ({1'b0, base_addr} >= (ADDR_W + 1)'(MEM_WORDS)) begin
      base_wrapped = base_addr - ADDR_W'(MEM_WORDS);
    end
    addr_next = (addr_q == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
  end

`ifdef FETCH_BYTESWAP_EN
  // Little-endian message storage: reverse byte order so the cores see big-endian words.
  always_comb begin
    wdata = '0;
    for (int b = 0; b < int'(DATA_W / 8); b++) begin
      wdata[8*b +: 8] = bus.mem_readdata[DATA_W - 8 - 8*b +: 8];
    end
  end
`else
  assign wdata = bus.mem_readdata;
`endif

  // Job control FSM with registered busy/done; start is only looked at in StIdle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
      beat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q   <= 1'b1;
            addr_q   <= base_wrapped;
            remain_q <= total_words;
            beat_q   <= '0;
            state_q  <= (num_blocks == '0) ? StDone : StFetch;
          end
        end
        StFetch: begin
          if (issue) begin
            addr_q   <= addr_next;
            remain_q <= remain_q - CntW'(1);
            beat_q   <= last_beat ? '0 : beat_q + BeatW'(1);
            if (remain_q == CntW'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if ((count_q == '0) && !inflight_q) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tracks the read issued last cycle; its data is on mem_readdata this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && last_beat;
    end
  end

  // FIFO storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wptr_q] <= wdata;
      fifo_last_q[wptr_q] <= inflight_last_q;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  assign bus.mem_address    = addr_q;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_writedata  = '0;
  assign bus.mem_clken      = 1'b1;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? fifo_data_q[rptr_q] : '0;
  assign bus.out_last  = out_valid ? fifo_last_q[rptr_q] : 1'b0;

endmodule

// File: tb/tb_onchip_block_fetcher.sv
// Self-checking bench for onchip_block_fetcher: a RAM model answers reads, a
// behavioural model predicts reads, stream words and busy/done each cycle, and
// directed scenarios pin a few literal values. Honors FETCH_BYTESWAP_EN.

`timescale 1ns/1ps

module tb_onchip_block_fetcher;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned MEM_WORDS   = 64000;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned FIFO_DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] num_blocks = '0;
  logic        busy;
  logic        done;

  onchip_block_fetcher_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_block_fetcher #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS),
    .BLOCK_WORDS(BLOCK_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_blocks(num_blocks), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // RAM contents: a fixed word at 0x0100, an address hash elsewhere.
  function automatic logic [31:0] ram_word(input logic [15:0] a);
    if (a == 16'h0100) return 32'h11223344;
    return {a ^ 16'hA5C3, ~a} ^ 32'h13572468;
  endfunction

  function automatic logic [31:0] exp_word(input logic [15:0] a);
    logic [31:0] w;
    w = ram_word(a);
`ifdef FETCH_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // RAM with 1-cycle read latency
  initial bus.mem_readdata = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_chipselect) bus.mem_readdata <= ram_word(bus.mem_address);
  end

  // Consumer: 0 = always ready, 1 = random, 2 = stalled
  int ready_mode = 0;
  initial bus.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Behavioural model: outstanding = reads issued - words taken; data returns 2 cycles later
  int          m_active, m_reads_left, m_words_left, m_fifo, m_inflight, m_done_ctr, m_issue_idx;
  logic [15:0] m_addr;
  logic [15:0] q_addr[$];
  int          q_idx[$];
  logic        exp_cs, exp_valid, exp_done, exp_busy, pop;
  int          arrive;

  // Per-job observations for the directed literal checks
  int          st_reads, st_words, st_lasts, st_last1, st_last2, st_dones, st_first_cs, st_last_cs;
  logic [15:0] st_addrs[64];
  logic [31:0] st_data[64];

  function automatic void model_reset();
    m_active = 0; m_reads_left = 0; m_words_left = 0; m_fifo = 0; m_inflight = 0;
    m_done_ctr = 0; m_issue_idx = 0; m_addr = '0;
    q_addr.delete(); q_idx.delete();
  endfunction

  task automatic clear_stats();
    st_reads = 0; st_words = 0; st_lasts = 0; st_last1 = 0; st_last2 = 0; st_dones = 0;
    st_first_cs = 0; st_last_cs = 0;
    for (int i = 0; i < 64; i++) begin st_addrs[i] = '1; st_data[i] = '0; end
  endtask

  // Compare process: check the current cycle, then advance the model by one cycle
  always @(negedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      exp_cs    = (m_active != 0) && (m_reads_left > 0) && ((m_fifo + m_inflight) < FIFO_DEPTH);
      exp_valid = (m_fifo > 0);
      exp_done  = (m_done_ctr == 1);
      exp_busy  = (m_active != 0) && !exp_done;

      check("mem_chipselect", bus.mem_chipselect, exp_cs);
      if (exp_cs) begin
        check("mem_address", bus.mem_address, m_addr);
        check("mem_write", bus.mem_write, 1'b0);
        check("mem_byteenable", bus.mem_byteenable, 4'hF);
      end
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("out_valid", bus.out_valid, exp_valid);
      if (exp_valid && q_addr.size() > 0) begin
        check("out_data", bus.out_data, exp_word(q_addr[0]));
        check("out_last", bus.out_last, (q_idx[0] % BLOCK_WORDS) == (BLOCK_WORDS - 1));
      end

      if (bus.mem_chipselect) begin
        if (st_reads < 64) st_addrs[st_reads] = bus.mem_address;
        if (st_reads == 0) st_first_cs = cyc;
        st_last_cs = cyc;
        st_reads++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (st_words < 64) st_data[st_words] = bus.out_data;
        st_words++;
        if (bus.out_last) begin
          st_lasts++;
          if (st_lasts == 1) st_last1 = st_words;
          if (st_lasts == 2) st_last2 = st_words;
        end
      end
      if (done) st_dones++;

      pop    = exp_valid && bus.out_ready && (q_addr.size() > 0);
      arrive = m_inflight;
      m_inflight = exp_cs ? 1 : 0;
      if (exp_cs) begin
        q_addr.push_back(m_addr);
        q_idx.push_back(m_issue_idx);
        m_issue_idx++;
        m_reads_left--;
        m_addr = (m_addr == 16'(MEM_WORDS - 1)) ? 16'h0 : m_addr + 16'h1;
      end
      m_fifo = m_fifo + arrive - (pop ? 1 : 0);
      if (pop) begin
        void'(q_addr.pop_front());
        void'(q_idx.pop_front());
        m_words_left--;
      end
      if (m_done_ctr > 0) begin
        m_done_ctr--;
        if (m_done_ctr == 0) m_active = 0;
      end
      if (pop && m_words_left == 0) m_done_ctr = 3;
      if (start && m_active == 0) begin
        m_active     = 1;
        m_addr       = 16'(int'(base_addr) % int'(MEM_WORDS));
        m_reads_left = int'(num_blocks) * BLOCK_WORDS;
        m_words_left = m_reads_left;
        m_issue_idx  = 0;
        if (num_blocks == 0) m_done_ctr = 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] n);
    base_addr  = b;
    num_blocks = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (st_dones == 0 && n < budget) begin
      tick();
      n++;
    end
    check("job completes within budget", st_dones != 0, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b;
    clear_stats();
    tick(); tick(); tick();
    // Reset state
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset chipselect", bus.mem_chipselect, 1'b0);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset out_data", bus.out_data, 32'h0);
    check("reset out_last", bus.out_last, 1'b0);
    check("reset mem_address", bus.mem_address, 16'h0);
    check("reset byteenable", bus.mem_byteenable, 4'hF);
    check("reset clken", bus.mem_clken, 1'b1);
    check("reset write", bus.mem_write, 1'b0);
    check("reset writedata", bus.mem_writedata, 32'h0);
    reset = 1'b0;
    tick();

    // 1: single block from 0x0010 with consumer always ready
    clear_stats();
    ready_mode = 0;
    do_start(16'h0010, 16'd1);
    wait_done(200);
    check("t1 reads", st_reads, 16);
    check("t1 read span cycles", st_last_cs - st_first_cs + 1, 16);
    check("t1 first addr", st_addrs[0], 16'h0010);
    check("t1 last addr", st_addrs[15], 16'h001F);
    check("t1 words", st_words, 16);
    check("t1 last count", st_lasts, 1);
    check("t1 last position", st_last1, 16);
    check("t1 done pulses", st_dones, 1);

    // 2: two blocks with the consumer stalled for 20 cycles
    clear_stats();
    ready_mode = 2;
    tick();
    do_start(16'h0200, 16'd2);
    repeat (20) tick();
    check("t2 reads while stalled", st_reads, 4);
    check("t2 words while stalled", st_words, 0);
    check("t2 fifo head valid", bus.out_valid, 1'b1);
    ready_mode = 0;
    wait_done(300);
    check("t2 reads", st_reads, 32);
    check("t2 words", st_words, 32);
    check("t2 last count", st_lasts, 2);
    check("t2 first last", st_last1, 16);
    check("t2 second last", st_last2, 32);

    // 3: address wrap at the top of the RAM
    clear_stats();
    do_start(16'd63992, 16'd1);
    wait_done(200);
    check("t3 addr before wrap", st_addrs[7], 16'd63999);
    check("t3 addr after wrap", st_addrs[8], 16'd0);
    check("t3 final addr", st_addrs[15], 16'd7);
    check("t3 read span cycles", st_last_cs - st_first_cs + 1, 16);
    check("t3 words", st_words, 16);

    // 4: zero-block job
    clear_stats();
    do_start(16'h0040, 16'd0);
    check("t4 busy cycle 1", busy, 1'b1);
    check("t4 done cycle 1", done, 1'b0);
    tick();
    check("t4 busy cycle 2", busy, 1'b0);
    check("t4 done cycle 2", done, 1'b1);
    tick();
    check("t4 done cycle 3", done, 1'b0);
    tick();
    check("t4 reads", st_reads, 0);
    check("t4 done pulses", st_dones, 1);

    // 5: reset in the middle of a job, then a fresh job
    clear_stats();
    do_start(16'h0300, 16'd1);
    n = 0;
    while (st_words < 5 && n < 100) begin tick(); n++; end
    check("t5 reached 5 words", st_words >= 5, 1'b1);
    reset = 1'b1;
    tick();
    check("t5 out_valid after reset", bus.out_valid, 1'b0);
    check("t5 busy after reset", busy, 1'b0);
    check("t5 chipselect after reset", bus.mem_chipselect, 1'b0);
    reset = 1'b0;
    repeat (10) tick();
    check("t5 no done after reset", st_dones, 0);
    clear_stats();
    do_start(16'h0400, 16'd1);
    wait_done(200);
    check("t5 fresh reads", st_reads, 16);
    check("t5 fresh first addr", st_addrs[0], 16'h0400);
    check("t5 fresh words", st_words, 16);

    // 6: second start mid-job is ignored; word at 0x0100 shows the byte order
    clear_stats();
    do_start(16'h00F8, 16'd1);
    repeat (4) tick();
    do_start(16'h5000, 16'd3);
    wait_done(200);
    check("t6 reads", st_reads, 16);
    check("t6 words", st_words, 16);
`ifdef FETCH_BYTESWAP_EN
    check("t6 word at 0x0100", st_data[8], 32'h44332211);
`else
    check("t6 word at 0x0100", st_data[8], 32'h11223344);
`endif

    // Randomised jobs: random base (incl. wrap and out-of-range), length and back-pressure
    for (int j = 0; j < 10; j++) begin
      clear_stats();
      ready_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       b = $urandom_range(0, 65535);
        1:       b = $urandom_range(63980, 63999);
        default: b = $urandom_range(64000, 65535);
      endcase
      n = $urandom_range(0, 3);
      do_start(16'(b), 16'(n));
      wait_done(1000);
      check("rand words", st_words, n * 16);
      check("rand done pulses", st_dones, 1);
    end

    ready_mode = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
